uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: two-flop input synchroniser, 3-sample majority vote per bit,
// false-start rejection, and a single-cycle valid strobe carrying per-frame parity and framing status.
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    output logic                 recieve_flag,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam int NB  = 1 + DATA_BITS + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
    localparam int MID = OVERSAMPLE / 2;
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(NB + 1);

    // Samples are taken on the edges where cnt advances to MID-1, MID and MID+1.
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 2);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S2   = CW'(MID);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIDX_LAST_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] BIDX_LAST_STOP = BW'(NB - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_check(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY_MODE == 1)      return (^d) ^ p;
        else if (PARITY_MODE == 2) return ~((^d) ^ p);
        else                       return 1'b0;
    endfunction

    logic [1:0]           sync_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbit_q, pbit_d;
    logic                 ferr_q, ferr_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 rflag_q, rflag_d;
    logic                 perr_q, perr_d;
    logic                 frerr_q, frerr_d;
    logic                 din_s, vote, vote_edge, wrap;

    assign din_s     = sync_q[1];
    assign vote      = maj3(v0_q, v1_q, din_s);
    assign vote_edge = (cnt_q == CNT_S2);
    assign wrap      = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        bidx_d  = bidx_q;
        shift_d = shift_q;
        pbit_d  = pbit_q;
        ferr_d  = ferr_q;
        v0_d    = (cnt_q == CNT_S0) ? din_s : v0_q;
        v1_d    = (cnt_q == CNT_S1) ? din_s : v1_q;
        out_d   = out_q;
        valid_d = 1'b0;
        rflag_d = rflag_q;
        perr_d  = perr_q;
        frerr_d = frerr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!din_s) begin
                    state_d = START;
                    bidx_d  = '0;
                    ferr_d  = 1'b0;
                    rflag_d = 1'b1;
                end
            end
            START: begin
                if (vote_edge && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rflag_d = 1'b0;
                end else if (wrap) begin
                    state_d = DATA;
                    bidx_d  = bidx_q + BW'(1);
                end
            end
            DATA: begin
                if (vote_edge) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    bidx_d = bidx_q + BW'(1);
                    if (bidx_q == BIDX_LAST_DATA) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (vote_edge) pbit_d = vote;
                if (wrap) begin
                    bidx_d  = bidx_q + BW'(1);
                    state_d = STOP;
                end
            end
            STOP: begin
                // The frame completes at the last stop vote; the rest of that stop bit is spent in IDLE.
                if (vote_edge) begin
                    ferr_d = ferr_q | ~vote;
                    if (bidx_q == BIDX_LAST_STOP) begin
                        out_d   = shift_q;
                        perr_d  = parity_check(shift_q, pbit_q);
                        frerr_d = ferr_q | ~vote;
                        valid_d = 1'b1;
                        rflag_d = 1'b0;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (wrap) begin
                    bidx_d = bidx_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            out_q   <= '0;
            valid_q <= 1'b0;
            rflag_q <= 1'b0;
            perr_q  <= 1'b0;
            frerr_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            rflag_q <= rflag_d;
            perr_q  <= perr_d;
            frerr_q <= frerr_d;
        end
    end

    assign out          = out_q;
    assign valid        = valid_q;
    assign recieve_flag = rflag_q;
    assign parity_err   = perr_q;
    assign frame_err    = frerr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 7O2) driven with directed and random frames,
// each checked against a frame-level model of data, parity, framing and valid timing.
module tb_uart_rx_os;
    localparam int OS = 16;
    localparam int DB [3] = '{8, 8, 7};
    localparam int PM [3] = '{0, 1, 2};
    localparam int SB [3] = '{1, 1, 2};

    typedef struct packed {
        logic [31:0] cyc;
        logic [8:0]  data;
        logic        perr;
        logic        ferr;
    } rec_t;

    logic       clk;
    logic       rstn [3];
    logic       din  [3];
    logic [7:0] o0, o1;
    logic [6:0] o2;
    logic       v0, v1, v2, rf0, rf1, rf2, pe0, pe1, pe2, fe0, fe1, fe2;

    int   cyc;
    int   ncmp;
    int   nfail;
    rec_t rq0[$], rq1[$], rq2[$];

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .baud_clk(clk), .reset(rstn[0]), .din(din[0]), .out(o0), .valid(v0),
        .recieve_flag(rf0), .parity_err(pe0), .frame_err(fe0));
    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .baud_clk(clk), .reset(rstn[1]), .din(din[1]), .out(o1), .valid(v1),
        .recieve_flag(rf1), .parity_err(pe1), .frame_err(fe1));
    uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
        .baud_clk(clk), .reset(rstn[2]), .din(din[2]), .out(o2), .valid(v2),
        .recieve_flag(rf2), .parity_err(pe2), .frame_err(fe2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, logging every valid strobe seen on any receiver.
    task automatic step(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (v0) begin r.cyc = cyc; r.data = 9'(o0); r.perr = pe0; r.ferr = fe0; rq0.push_back(r); end
            if (v1) begin r.cyc = cyc; r.data = 9'(o1); r.perr = pe1; r.ferr = fe1; rq1.push_back(r); end
            if (v2) begin r.cyc = cyc; r.data = 9'(o2); r.perr = pe2; r.ferr = fe2; rq2.push_back(r); end
        end
    endtask

    function automatic int qsize(input int inst);
        case (inst)
            0:       return rq0.size();
            1:       return rq1.size();
            default: return rq2.size();
        endcase
    endfunction

    task automatic pop_rec(input int inst, output rec_t r);
        case (inst)
            0:       r = rq0.pop_front();
            1:       r = rq1.pop_front();
            default: r = rq2.pop_front();
        endcase
    endtask

    function automatic logic rflag_of(input int inst);
        case (inst)
            0:       return rf0;
            1:       return rf1;
            default: return rf2;
        endcase
    endfunction

    task automatic check_idle_outputs(input int inst, input logic [8:0] exp_out);
        case (inst)
            0:       begin check("out0", 32'(o0), 32'(exp_out)); check("valid0", 32'(v0), 0); check("rflag0", 32'(rf0), 0);
                           check("perr0", 32'(pe0), 0); check("ferr0", 32'(fe0), 0); end
            1:       begin check("out1", 32'(o1), 32'(exp_out)); check("valid1", 32'(v1), 0); check("rflag1", 32'(rf1), 0);
                           check("perr1", 32'(pe1), 0); check("ferr1", 32'(fe1), 0); end
            default: begin check("out2", 32'(o2), 32'(exp_out)); check("valid2", 32'(v2), 0); check("rflag2", 32'(rf2), 0);
                           check("perr2", 32'(pe2), 0); check("ferr2", 32'(fe2), 0); end
        endcase
    endtask

    // Drive one frame bit-by-bit, then compare the logged strobe with the frame model.
    task automatic send_frame(input int inst, input logic [8:0] data, input logic pb,
                              input logic [1:0] stops, input int gap);
        logic       bits[$];
        logic [8:0] mask, d;
        logic       ep, ef;
        int         t0, nb, ones, lat, n;
        rec_t       r;
        mask = 9'((1 << DB[inst]) - 1);
        d    = data & mask;
        bits.push_back(1'b0);
        for (int i = 0; i < DB[inst]; i++) bits.push_back(d[i]);
        if (PM[inst] != 0) bits.push_back(pb);
        for (int i = 0; i < SB[inst]; i++) bits.push_back(stops[i]);
        nb = bits.size();
        t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            din[inst] = bits[i];
            step(OS);
            if (i == 0) check("rflag_in_frame", 32'(rflag_of(inst)), 1);
        end
        ones = $countones(d);
        ep   = (PM[inst] == 1) ? (((ones + int'(pb)) % 2) == 1) :
               (PM[inst] == 2) ? (((ones + int'(pb)) % 2) == 0) : 1'b0;
        ef   = (stops[0] == 1'b0) || (SB[inst] == 2 && stops[1] == 1'b0);
        // Three cycles of synchroniser plus detect, then the last stop vote lands mid-bit.
        lat  = 3 + (nb - 1) * OS + OS / 2 + 1;
        // A low final stop bit is taken as a fresh start right after valid.
        check("rflag_frame_end", 32'(rflag_of(inst)), 32'(stops[SB[inst]-1] == 1'b0));
        n = qsize(inst);
        check("valid_count", 32'(n), 1);
        if (n > 0) begin
            pop_rec(inst, r);
            check("out", 32'(r.data), 32'(d));
            check("parity_err", 32'(r.perr), 32'(ep));
            check("frame_err", 32'(r.ferr), 32'(ef));
            check("latency", r.cyc - 32'(t0), 32'(lat));
        end
        while (qsize(inst) > 0) pop_rec(inst, r);
        din[inst] = 1'b1;
        step(gap);
    endtask

    initial begin
        rec_t       r;
        int         t0;
        logic [8:0] rd;
        logic [1:0] rs;
        logic       rp;
        cyc   = 0;
        ncmp  = 0;
        nfail = 0;
        for (int i = 0; i < 3; i++) begin rstn[i] = 1'b0; din[i] = 1'b1; end
        step(3);
        for (int i = 0; i < 3; i++) check_idle_outputs(i, 9'h0);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        step(20);

        // 8N1 reference frame.
        send_frame(0, 9'hA5, 1'b0, 2'b11, 20);

        // Short glitch: start is taken, then rejected by the vote.
        din[0] = 1'b0;
        step(4);
        din[0] = 1'b1;
        check("glitch_rflag_high", 32'(rf0), 1);
        step(12);
        check("glitch_rflag_low", 32'(rf0), 0);
        step(40);
        check("glitch_no_valid", 32'(rq0.size()), 0);
        check("glitch_out_held", 32'(o0), 32'h0A5);

        // Even parity: wrong then right parity bit.
        send_frame(1, 9'h03, 1'b1, 2'b11, 5);
        send_frame(1, 9'h03, 1'b0, 2'b11, 5);

        // Framing error then a clean frame.
        send_frame(0, 9'h5A, 1'b0, 2'b10, OS);
        send_frame(0, 9'h81, 1'b0, 2'b11, 5);

        // Reset during data bit 4 aborts the frame.
        din[0] = 1'b0;
        step(OS);
        for (int i = 0; i < 4; i++) begin din[0] = i[0]; step(OS); end
        din[0] = 1'b1;
        step(8);
        rstn[0] = 1'b0;
        step(1);
        rstn[0] = 1'b1;
        check_idle_outputs(0, 9'h0);
        step(200);
        check("reset_no_valid", 32'(rq0.size()), 0);
        send_frame(0, 9'h3C, 1'b0, 2'b11, 5);

        // 7O2 back-to-back, then a bad second stop bit.
        send_frame(2, 9'h41, 1'b1, 2'b11, 0);
        send_frame(2, 9'h7F, 1'b0, 2'b11, 0);
        send_frame(2, 9'h2B, 1'b1, 2'b01, OS);

        // Break: line held low through two frames.
        t0     = cyc;
        din[0] = 1'b0;
        step(310);
        din[0] = 1'b1;
        step(40);
        check("break_valid_count", 32'(rq0.size()), 2);
        for (int k = 0; k < 2; k++) begin
            if (rq0.size() > 0) begin
                r = rq0.pop_front();
                check("break_out", 32'(r.data), 0);
                check("break_ferr", 32'(r.ferr), 1);
                check("break_latency", r.cyc - 32'(t0), 32'(156 + k * 154));
            end
        end
        check("break_rflag_end", 32'(rf0), 0);

        // Random frames on every receiver.
        for (int inst = 0; inst < 3; inst++) begin
            for (int k = 0; k < 6; k++) begin
                rd = 9'($urandom);
                rp = (PM[inst] == 2) ? ~^(rd & 9'((1 << DB[inst]) - 1)) : ^(rd & 9'((1 << DB[inst]) - 1));
                if ($urandom_range(0, 3) == 0) rp = ~rp;
                rs[0] = ($urandom_range(0, 3) != 0);
                rs[1] = ($urandom_range(0, 3) != 0);
                send_frame(inst, rd, rp, rs,
                           (rs[SB[inst]-1] == 1'b0) ? OS : int'($urandom_range(0, 2)));
            end
        end

        step(50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
